kd_bank_xbar: RTL and testbench

Pipelined bank crossbar between the 4-bank coefficient memory and the butterfly array for Kyber/Dilithium (K/D) modes. It consumes the per-request bank numbers and the bank-select vector produced by the bank arbiter. On the read side it returns the four coefficients to lane order. On the write-back side it steers the four butterfly results to their home banks using a tag FIFO that matches each result to its request.

---
 rtl/kd_bank_xbar.sv | 199 +++++++++++++++++++
 tb/tb_kd_bank_xbar.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kd_bank_xbar.sv
// Pipelined bank crossbar: lane-ordered read return plus tag-FIFO-steered write-back.
// Optional duplicate-bank check enabled by defining KD_BANK_CONFLICT_CHK_EN.
module kd_bank_xbar #(
    parameter int unsigned DW     = 24,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               a0,
    input  logic [1:0]               a1,
    input  logic [1:0]               a2,
    input  logic [1:0]               a3,
    input  logic [1:0]               sel_a_0,
    input  logic [1:0]               sel_a_1,
    input  logic [1:0]               sel_a_2,
    input  logic [1:0]               sel_a_3,
    input  logic [DW-1:0]            bank_rdata_0,
    input  logic [DW-1:0]            bank_rdata_1,
    input  logic [DW-1:0]            bank_rdata_2,
    input  logic [DW-1:0]            bank_rdata_3,
    output logic                     out_valid,
    output logic [DW-1:0]            coef_0,
    output logic [DW-1:0]            coef_1,
    output logic [DW-1:0]            coef_2,
    output logic [DW-1:0]            coef_3,
    input  logic                     wb_valid,
    input  logic [DW-1:0]            wb_coef_0,
    input  logic [DW-1:0]            wb_coef_1,
    input  logic [DW-1:0]            wb_coef_2,
    input  logic [DW-1:0]            wb_coef_3,
    output logic                     bank_we,
    output logic [DW-1:0]            bank_wdata_0,
    output logic [DW-1:0]            bank_wdata_1,
    output logic [DW-1:0]            bank_wdata_2,
    output logic [DW-1:0]            bank_wdata_3,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     wb_err,
    output logic                     conflict_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [7:0]    req_a;
    logic [7:0]    req_sel;
    logic [DW-1:0] rdata [4];
    logic [DW-1:0] wbc   [4];
    logic          accept;
    logic          push;
    logic          pop;

    logic [RD_LAT-1:0] sr_v_q;
    logic [7:0]        sr_a_q [RD_LAT];
    logic              em_v;
    logic [7:0]        em_a;

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    head;

    logic          out_valid_q;
    logic [DW-1:0] coef_q  [4];
    logic [DW-1:0] coef_d  [4];
    logic          we_q;
    logic [DW-1:0] wdata_q [4];
    logic [DW-1:0] wdata_d [4];
    logic          wb_err_q;

    assign req_a   = {a3, a2, a1, a0};
    assign req_sel = {sel_a_3, sel_a_2, sel_a_1, sel_a_0};
    assign rdata[0] = bank_rdata_0;
    assign rdata[1] = bank_rdata_1;
    assign rdata[2] = bank_rdata_2;
    assign rdata[3] = bank_rdata_3;
    assign wbc[0]   = wb_coef_0;
    assign wbc[1]   = wb_coef_1;
    assign wbc[2]   = wb_coef_2;
    assign wbc[3]   = wb_coef_3;

    assign in_ready = !rst && (level_q < DEPTH_L);

`ifdef KD_BANK_CONFLICT_CHK_EN
    logic dup;
    logic conflict_q;

    assign dup = (a0 == a1) || (a0 == a2) || (a0 == a3) ||
                 (a1 == a2) || (a1 == a3) || (a2 == a3);
    // Conflicting requests are dropped silently; the flag is the only trace.
    assign accept       = in_valid && in_ready && !dup;
    assign conflict_err = conflict_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else if (in_valid && dup) begin
            conflict_q <= 1'b1;
        end
    end
`else
    assign accept       = in_valid && in_ready;
    assign conflict_err = 1'b0;
`endif

    assign push = accept;
    assign pop  = wb_valid && (level_q != '0);
    assign em_v = sr_v_q[RD_LAT-1];
    assign em_a = sr_a_q[RD_LAT-1];
    assign head = fifo_mem[rd_ptr_q];

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            coef_d[i]  = coef_q[i];
            wdata_d[i] = wdata_q[i];
        end
        if (em_v) begin
            for (int unsigned i = 0; i < 4; i++) begin
                coef_d[i] = rdata[em_a[2*i +: 2]];
            end
        end
        if (pop) begin
            for (int unsigned j = 0; j < 4; j++) begin
                wdata_d[j] = wbc[head[2*j +: 2]];
            end
        end
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= req_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_v_q      <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                sr_a_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            we_q        <= 1'b0;
            wb_err_q    <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                coef_q[i]  <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            sr_v_q[0] <= accept;
            sr_a_q[0] <= req_a;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                sr_v_q[i] <= sr_v_q[i-1];
                sr_a_q[i] <= sr_a_q[i-1];
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q     <= level_d;
            out_valid_q <= em_v;
            we_q        <= pop;
            if (wb_valid && (level_q == '0)) begin
                wb_err_q <= 1'b1;
            end
            for (int unsigned i = 0; i < 4; i++) begin
                coef_q[i]  <= coef_d[i];
                wdata_q[i] <= wdata_d[i];
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign coef_0       = coef_q[0];
    assign coef_1       = coef_q[1];
    assign coef_2       = coef_q[2];
    assign coef_3       = coef_q[3];
    assign bank_we      = we_q;
    assign bank_wdata_0 = wdata_q[0];
    assign bank_wdata_1 = wdata_q[1];
    assign bank_wdata_2 = wdata_q[2];
    assign bank_wdata_3 = wdata_q[3];
    assign fifo_level   = level_q;
    assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_kd_bank_xbar.sv
// Bench for kd_bank_xbar: directed vector table, corner sequences, and random traffic
// checked against a queue-based reference model.
module tb_kd_bank_xbar;

    localparam int unsigned DW     = 24;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned DEPTH  = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    a   [4];
    logic [1:0]    sel [4];
    logic [DW-1:0] rd  [4];
    logic          out_valid;
    logic [DW-1:0] coef [4];
    logic          wb_valid;
    logic [DW-1:0] wbc [4];
    logic          bank_we;
    logic [DW-1:0] wdata [4];
    logic [$clog2(DEPTH):0] fifo_level;
    logic          wb_err;
    logic          conflict_err;

    kd_bank_xbar #(.DW(DW), .RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]),
        .sel_a_0(sel[0]), .sel_a_1(sel[1]), .sel_a_2(sel[2]), .sel_a_3(sel[3]),
        .bank_rdata_0(rd[0]), .bank_rdata_1(rd[1]), .bank_rdata_2(rd[2]), .bank_rdata_3(rd[3]),
        .out_valid(out_valid),
        .coef_0(coef[0]), .coef_1(coef[1]), .coef_2(coef[2]), .coef_3(coef[3]),
        .wb_valid(wb_valid),
        .wb_coef_0(wbc[0]), .wb_coef_1(wbc[1]), .wb_coef_2(wbc[2]), .wb_coef_3(wbc[3]),
        .bank_we(bank_we),
        .bank_wdata_0(wdata[0]), .bank_wdata_1(wdata[1]),
        .bank_wdata_2(wdata[2]), .bank_wdata_3(wdata[3]),
        .fifo_level(fifo_level), .wb_err(wb_err), .conflict_err(conflict_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding reads with their due cycle, and outstanding tags.
    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  a;
    } rd_t;
    rd_t           rdq  [$];
    logic [7:0]    tagq [$];
    int unsigned   cyc = 0;
    logic          e_ov, e_we, e_err, e_cerr;
    logic [DW-1:0] e_coef [4];
    logic [DW-1:0] e_wd   [4];

    typedef struct packed {
        logic [7:0]  a;
        logic [95:0] rdv;
        logic [95:0] ecoef;
        logic [7:0]  sel;
        logic [95:0] wbv;
        logic [95:0] ewd;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        logic [7:0] h;
        logic [7:0] pa;
        logic [7:0] ps;
        rd_t        r;
        bit         dup;
        bit         acc;
        pa = {a[3], a[2], a[1], a[0]};
        ps = {sel[3], sel[2], sel[1], sel[0]};
        if (rst) begin
            rdq.delete();
            tagq.delete();
            e_ov = 0; e_we = 0; e_err = 0; e_cerr = 0;
        end else begin
            dup = 0;
            for (int i = 0; i < 4; i++)
                for (int k = i + 1; k < 4; k++)
                    if (a[i] == a[k]) dup = 1;
            acc = in_valid && (tagq.size() < DEPTH);
`ifdef KD_BANK_CONFLICT_CHK_EN
            if (in_valid && dup) begin
                e_cerr = 1;
                acc = 0;
            end
`endif
            e_ov = 0;
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                r = rdq.pop_front();
                e_ov = 1;
                for (int i = 0; i < 4; i++) e_coef[i] = rd[r.a[2*i +: 2]];
            end
            e_we = 0;
            if (wb_valid) begin
                if (tagq.size() > 0) begin
                    h = tagq.pop_front();
                    e_we = 1;
                    for (int j = 0; j < 4; j++) e_wd[j] = wbc[h[2*j +: 2]];
                end else begin
                    e_err = 1;
                end
            end
            if (acc) begin
                rdq.push_back('{due: cyc + RD_LAT, a: pa});
                tagq.push_back(ps);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        if (e_ov)
            for (int i = 0; i < 4; i++) chk($sformatf("coef_%0d", i), 64'(coef[i]), 64'(e_coef[i]));
        chk("bank_we", 64'(bank_we), 64'(e_we));
        if (e_we)
            for (int j = 0; j < 4; j++) chk($sformatf("bank_wdata_%0d", j), 64'(wdata[j]), 64'(e_wd[j]));
        chk("fifo_level", 64'(fifo_level), 64'(tagq.size()));
        chk("in_ready", 64'(in_ready), 64'(!rst && (tagq.size() < DEPTH)));
        chk("wb_err", 64'(wb_err), 64'(e_err));
        chk("conflict_err", 64'(conflict_err), 64'(e_cerr));
    endtask

    task automatic set_a(input logic [7:0] p);
        for (int i = 0; i < 4; i++) a[i] = p[2*i +: 2];
    endtask

    task automatic set_sel(input logic [7:0] p);
        for (int i = 0; i < 4; i++) sel[i] = p[2*i +: 2];
    endtask

    task automatic rand_perm(output logic [7:0] p);
        logic [1:0] v [4];
        logic [1:0] t;
        int unsigned k;
        for (int i = 0; i < 4; i++) v[i] = 2'(i);
        for (int i = 3; i > 0; i--) begin
            k = $urandom_range(i, 0);
            t = v[i]; v[i] = v[k]; v[k] = t;
        end
        p = {v[3], v[2], v[1], v[0]};
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) begin
            rd[i]  = DW'($urandom);
            wbc[i] = DW'($urandom);
        end
    endtask

    task automatic idle();
        in_valid = 0;
        wb_valid = 0;
    endtask

    initial begin
        logic [7:0] p;
        int lvl;

        // {a}, {rdata}, {coef}, {sel}, {wb_coef}, {wdata}; lane 0 in the low field
        tbl[0] = '{a: {2'd1, 2'd3, 2'd0, 2'd2},
                   rdv: {24'd13, 24'd12, 24'd11, 24'd10}, ecoef: {24'd11, 24'd13, 24'd10, 24'd12},
                   sel: {2'd2, 2'd0, 2'd3, 2'd1},
                   wbv: {24'd103, 24'd102, 24'd101, 24'd100}, ewd: {24'd102, 24'd100, 24'd103, 24'd101}};
        tbl[1] = '{a: {2'd3, 2'd2, 2'd1, 2'd0},
                   rdv: {24'd8, 24'd7, 24'd6, 24'd5}, ecoef: {24'd8, 24'd7, 24'd6, 24'd5},
                   sel: {2'd0, 2'd1, 2'd2, 2'd3},
                   wbv: {24'd4, 24'd3, 24'd2, 24'd1}, ewd: {24'd1, 24'd2, 24'd3, 24'd4}};
        tbl[2] = '{a: {2'd0, 2'd1, 2'd2, 2'd3},
                   rdv: {24'h444, 24'h333, 24'h222, 24'h111}, ecoef: {24'h111, 24'h222, 24'h333, 24'h444},
                   sel: {2'd0, 2'd1, 2'd2, 2'd2},
                   wbv: {24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA},
                   ewd: {24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 24'hCCCCCC}};
        tbl[3] = '{a: {2'd1, 2'd2, 2'd3, 2'd0},
                   rdv: {24'h000001, 24'hFFFFFF, 24'h123456, 24'hABCDEF},
                   ecoef: {24'h123456, 24'hFFFFFF, 24'h000001, 24'hABCDEF},
                   sel: {2'd3, 2'd3, 2'd3, 2'd3},
                   wbv: {24'h0F0F0F, 24'hF0F0F0, 24'h00FF00, 24'hFF00FF},
                   ewd: {24'h0F0F0F, 24'h0F0F0F, 24'h0F0F0F, 24'h0F0F0F}};

        rst = 1;
        idle();
        for (int i = 0; i < 4; i++) begin
            a[i] = 2'(i); sel[i] = 2'(i); rd[i] = '0; wbc[i] = '0;
        end
        step();
        step();
        rst = 0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_coef_0", 64'(coef[0]), 64'd0);
        chk("reset_wdata_0", 64'(wdata[0]), 64'd0);

        // Table: request, then next cycle bank data and write-back together
        for (int r = 0; r < 4; r++) begin
            set_a(tbl[r].a);
            set_sel(tbl[r].sel);
            in_valid = 1;
            wb_valid = 0;
            step();
            in_valid = 0;
            wb_valid = 1;
            for (int i = 0; i < 4; i++) begin
                rd[i]  = tbl[r].rdv[24*i +: 24];
                wbc[i] = tbl[r].wbv[24*i +: 24];
            end
            step();
            chk("tbl_out_valid", 64'(out_valid), 64'd1);
            chk("tbl_bank_we", 64'(bank_we), 64'd1);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("tbl%0d_coef_%0d", r, i), 64'(coef[i]), 64'(tbl[r].ecoef[24*i +: 24]));
                chk($sformatf("tbl%0d_wdata_%0d", r, i), 64'(wdata[i]), 64'(tbl[r].ewd[24*i +: 24]));
            end
            chk("tbl_level", 64'(fifo_level), 64'd0);
            idle();
            step();
        end

        // Fill the tag FIFO, attempt a ninth push, then drain in order
        for (int n = 0; n < 8; n++) begin
            rand_perm(p); set_a(p);
            rand_perm(p); set_sel(p);
            rand_data();
            in_valid = 1;
            step();
        end
        chk("full_level", 64'(fifo_level), 64'd8);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("full_ninth_level", 64'(fifo_level), 64'd8);
        in_valid = 0;
        for (int n = 0; n < 8; n++) begin
            rand_data();
            wb_valid = 1;
            step();
            if (n == 0) chk("pop_from_full_in_ready", 64'(in_ready), 64'd1);
        end
        chk("drained_level", 64'(fifo_level), 64'd0);
        idle();
        step();

        // Simultaneous push and pop at level 3, then an empty write-back
        for (int n = 0; n < 3; n++) begin
            rand_perm(p); set_a(p); rand_perm(p); set_sel(p);
            in_valid = 1;
            step();
        end
        in_valid = 1; wb_valid = 1; rand_data();
        step();
        chk("pushpop_level", 64'(fifo_level), 64'd3);
        in_valid = 0;
        for (int n = 0; n < 3; n++) begin
            rand_data();
            step();
        end
        wb_valid = 1;
        step();
        chk("empty_wb_we", 64'(bank_we), 64'd0);
        chk("empty_wb_err", 64'(wb_err), 64'd1);
        idle();
        step();
        chk("wb_err_held", 64'(wb_err), 64'd1);

        // Reset with reads still in flight and four tags outstanding
        for (int n = 0; n < 4; n++) begin
            rand_perm(p); set_a(p); rand_perm(p); set_sel(p);
            in_valid = 1;
            step();
        end
        in_valid = 0;
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_level", 64'(fifo_level), 64'd0);
        chk("rst_mid_wb_err", 64'(wb_err), 64'd0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("rst_mid_no_out", 64'(out_valid), 64'd0);
        end

        // Duplicate bank numbers
        lvl = int'(fifo_level);
        set_a({2'd3, 2'd2, 2'd1, 2'd1});
        rand_perm(p); set_sel(p);
        in_valid = 1;
        step();
        in_valid = 0;
        rand_data();
        step();
`ifdef KD_BANK_CONFLICT_CHK_EN
        chk("conflict_flag", 64'(conflict_err), 64'd1);
        chk("conflict_no_out", 64'(out_valid), 64'd0);
        chk("conflict_level", 64'(fifo_level), 64'(lvl));
`else
        chk("conflict_flag", 64'(conflict_err), 64'd0);
        chk("conflict_out", 64'(out_valid), 64'd1);
        chk("conflict_coef_dup", 64'(coef[0]), 64'(rd[1]));
        chk("conflict_level", 64'(fifo_level), 64'(lvl + 1));
`endif

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            rst      = ($urandom_range(59, 0) == 0);
            in_valid = ($urandom_range(9, 0) < 6);
            wb_valid = ($urandom_range(9, 0) < 4);
            if ($urandom_range(9, 0) < 7) begin
                rand_perm(p);
            end else begin
                p = 8'($urandom);
            end
            set_a(p);
            p = 8'($urandom);
            set_sel(p);
            rand_data();
            step();
        end
        rst = 0;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
